// File: rtl/mc_ctrl_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: states, opcodes, ALU codes,
// next-PC selects and trap causes.
package mc_ctrl_unit_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b010000;
  localparam logic [5:0] OpAndi  = 6'b010001;
  localparam logic [5:0] OpXori  = 6'b010010;
  localparam logic [5:0] OpBeq   = 6'b010011;
  localparam logic [5:0] OpBne   = 6'b010100;
  localparam logic [5:0] OpLw    = 6'b010101;
  localparam logic [5:0] OpSw    = 6'b010110;
  localparam logic [5:0] OpSlt   = 6'b010111;
  localparam logic [5:0] OpSlti  = 6'b011000;
  localparam logic [5:0] OpJ     = 6'b110000;

  localparam logic [2:0] AluAdd    = 3'b000;
  localparam logic [2:0] AluSub    = 3'b001;
  localparam logic [2:0] AluFunct  = 3'b010;
  localparam logic [2:0] AluAddImm = 3'b011;
  localparam logic [2:0] AluAnd    = 3'b100;
  localparam logic [2:0] AluXor    = 3'b101;
  localparam logic [2:0] AluSlt    = 3'b110;

  localparam logic [1:0] PcPlus4  = 2'd0;
  localparam logic [1:0] PcBranch = 2'd1;
  localparam logic [1:0] PcJump   = 2'd2;

  localparam logic [1:0] TrapNone    = 2'd0;
  localparam logic [1:0] TrapIllegal = 2'd1;
  localparam logic [1:0] TrapMemTo   = 2'd2;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: static datapath controls plus a legal-opcode flag.
module ctrl_decode
  import mc_ctrl_unit_pkg::*;
#(
  parameter int unsigned OPC_W    = 6,
  parameter int unsigned ALU_OP_W = 3
) (
  input  logic [OPC_W-1:0]    opcode_i,
  output logic                reg_dst_o,
  output logic                alu_src_o,
  output logic                mem_to_reg_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                legal_o
);

  logic [2:0] op;

  always_comb begin
    reg_dst_o    = 1'b0;
    alu_src_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    op           = AluAdd;
    legal_o      = 1'b1;
    case (opcode_i)
      OPC_W'(OpRtype): begin reg_dst_o = 1'b1; op = AluFunct;  end
      OPC_W'(OpAddi):  begin alu_src_o = 1'b1; op = AluAddImm; end
      OPC_W'(OpAndi):  begin alu_src_o = 1'b1; op = AluAnd;    end
      OPC_W'(OpXori):  begin alu_src_o = 1'b1; op = AluXor;    end
      OPC_W'(OpBeq):   op = AluSub;
      OPC_W'(OpBne):   op = AluSub;
      OPC_W'(OpLw):    begin alu_src_o = 1'b1; mem_to_reg_o = 1'b1; end
      OPC_W'(OpSw):    alu_src_o = 1'b1;
      OPC_W'(OpSlt):   begin reg_dst_o = 1'b1; op = AluFunct;  end
      OPC_W'(OpSlti):  begin alu_src_o = 1'b1; op = AluSlt;    end
      OPC_W'(OpJ):     op = AluAdd;
      default:         legal_o = 1'b0;
    endcase
    alu_op_o = ALU_OP_W'(op);
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle control FSM. Every output is a register loaded with the action of the
// state being left, so no input reaches an output combinationally.
module mc_ctrl_unit
  import mc_ctrl_unit_pkg::*;
#(
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned OPC_W    = 6,
  parameter int unsigned ALU_OP_W = 3,
  parameter int unsigned MEM_TO   = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_vld_i,
  output logic                instr_rdy_o,
  input  logic [INSTR_W-1:0]  instr_i,
  input  logic                zero_i,
  input  logic                mem_ack_i,
  output logic                reg_dst_o,
  output logic                alu_src_o,
  output logic                mem_to_reg_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                reg_wrt_o,
  output logic                mem_rd_o,
  output logic                mem_wrt_o,
  output logic                ir_wrt_o,
  output logic [1:0]          pc_src_o,
  output logic                retire_o,
  output logic                trap_o,
  output logic [1:0]          trap_cause_o
);

  state_e              state_q, state_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [7:0]          cnt_q, cnt_d, cnt_inc;
  logic                reg_dst_q, reg_dst_d, alu_src_q, alu_src_d, mem_to_reg_q, mem_to_reg_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic                reg_wrt_q, reg_wrt_d, mem_rd_q, mem_rd_d, mem_wrt_q, mem_wrt_d;
  logic                ir_wrt_q, ir_wrt_d, retire_q, retire_d, trap_q, trap_d;
  logic                instr_rdy_q, instr_rdy_d;
  logic [1:0]          pc_src_q, pc_src_d, trap_cause_q, trap_cause_d;

  logic                dec_reg_dst, dec_alu_src, dec_mem_to_reg, dec_legal;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                is_j, is_beq, is_bne, is_lw, is_sw, taken;
  logic                unused_instr;

  ctrl_decode #(
    .OPC_W    (OPC_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_ctrl_decode (
    .opcode_i     (opc_q),
    .reg_dst_o    (dec_reg_dst),
    .alu_src_o    (dec_alu_src),
    .mem_to_reg_o (dec_mem_to_reg),
    .alu_op_o     (dec_alu_op),
    .legal_o      (dec_legal)
  );

  assign unused_instr = ^instr_i[INSTR_W-OPC_W-1:0];
  assign is_j         = (opc_q == OPC_W'(OpJ));
  assign is_beq       = (opc_q == OPC_W'(OpBeq));
  assign is_bne       = (opc_q == OPC_W'(OpBne));
  assign is_lw        = (opc_q == OPC_W'(OpLw));
  assign is_sw        = (opc_q == OPC_W'(OpSw));
  assign taken        = is_beq ? zero_i : !zero_i;
  assign cnt_inc      = cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    cnt_d        = cnt_q;
    reg_dst_d    = reg_dst_q;
    alu_src_d    = alu_src_q;
    mem_to_reg_d = mem_to_reg_q;
    alu_op_d     = alu_op_q;
    ir_wrt_d     = 1'b0;
    reg_wrt_d    = 1'b0;
    mem_rd_d     = 1'b0;
    mem_wrt_d    = 1'b0;
    retire_d     = 1'b0;
    pc_src_d     = PcPlus4;
    trap_d       = trap_q;
    trap_cause_d = trap_cause_q;
    case (state_q)
      StFetch: begin
        if (instr_vld_i) begin
          ir_wrt_d = 1'b1;
          opc_d    = instr_i[INSTR_W-1 -: OPC_W];
          state_d  = StDecode;
        end
      end
      StDecode: begin
        reg_dst_d    = dec_reg_dst;
        alu_src_d    = dec_alu_src;
        mem_to_reg_d = dec_mem_to_reg;
        alu_op_d     = dec_alu_op;
        if (!dec_legal) begin
          state_d      = StTrap;
          trap_d       = 1'b1;
          trap_cause_d = TrapIllegal;
        end else if (is_j) begin
          pc_src_d = PcJump;
          retire_d = 1'b1;
          state_d  = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (is_beq || is_bne) begin
          retire_d = 1'b1;
          pc_src_d = taken ? PcBranch : PcPlus4;
          state_d  = StFetch;
        end else if (is_lw || is_sw) begin
          cnt_d     = '0;
          mem_rd_d  = is_lw;
          mem_wrt_d = is_sw;
          state_d   = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        // An ack in the timeout cycle still completes the access.
        if (mem_ack_i) begin
          if (is_lw) begin
            state_d = StWb;
          end else begin
            retire_d = 1'b1;
            state_d  = StFetch;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == 8'(MEM_TO)) begin
            state_d      = StTrap;
            trap_d       = 1'b1;
            trap_cause_d = TrapMemTo;
          end else begin
            mem_rd_d  = is_lw;
            mem_wrt_d = is_sw;
          end
        end
      end
      StWb: begin
        reg_wrt_d = 1'b1;
        retire_d  = 1'b1;
        state_d   = StFetch;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
    instr_rdy_d = (state_d == StFetch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      opc_q        <= '0;
      cnt_q        <= '0;
      reg_dst_q    <= 1'b0;
      alu_src_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_op_q     <= '0;
      reg_wrt_q    <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wrt_q    <= 1'b0;
      ir_wrt_q     <= 1'b0;
      retire_q     <= 1'b0;
      pc_src_q     <= PcPlus4;
      trap_q       <= 1'b0;
      trap_cause_q <= TrapNone;
      instr_rdy_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      opc_q        <= opc_d;
      cnt_q        <= cnt_d;
      reg_dst_q    <= reg_dst_d;
      alu_src_q    <= alu_src_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_op_q     <= alu_op_d;
      reg_wrt_q    <= reg_wrt_d;
      mem_rd_q     <= mem_rd_d;
      mem_wrt_q    <= mem_wrt_d;
      ir_wrt_q     <= ir_wrt_d;
      retire_q     <= retire_d;
      pc_src_q     <= pc_src_d;
      trap_q       <= trap_d;
      trap_cause_q <= trap_cause_d;
      instr_rdy_q  <= instr_rdy_d;
    end
  end

  assign instr_rdy_o  = instr_rdy_q;
  assign reg_dst_o    = reg_dst_q;
  assign alu_src_o    = alu_src_q;
  assign mem_to_reg_o = mem_to_reg_q;
  assign alu_op_o     = alu_op_q;
  assign reg_wrt_o    = reg_wrt_q;
  assign mem_rd_o     = mem_rd_q;
  assign mem_wrt_o    = mem_wrt_q;
  assign ir_wrt_o     = ir_wrt_q;
  assign pc_src_o     = pc_src_q;
  assign retire_o     = retire_q;
  assign trap_o       = trap_q;
  assign trap_cause_o = trap_cause_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench for mc_ctrl_unit; outputs are sampled on the falling clock edge.
module tb_mc_ctrl_unit;

  logic        clk;
  logic        rst_n;
  logic        instr_vld, instr_rdy;
  logic [31:0] instr;
  logic        zero, mem_ack;
  logic        reg_dst, alu_src, mem_to_reg;
  logic [2:0]  alu_op;
  logic        reg_wrt, mem_rd, mem_wrt, ir_wrt, retire, trap;
  logic [1:0]  pc_src, trap_cause;

  int checks = 0;
  int errors = 0;

  mc_ctrl_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_vld_i  (instr_vld),
    .instr_rdy_o  (instr_rdy),
    .instr_i      (instr),
    .zero_i       (zero),
    .mem_ack_i    (mem_ack),
    .reg_dst_o    (reg_dst),
    .alu_src_o    (alu_src),
    .mem_to_reg_o (mem_to_reg),
    .alu_op_o     (alu_op),
    .reg_wrt_o    (reg_wrt),
    .mem_rd_o     (mem_rd),
    .mem_wrt_o    (mem_wrt),
    .ir_wrt_o     (ir_wrt),
    .pc_src_o     (pc_src),
    .retire_o     (retire),
    .trap_o       (trap),
    .trap_cause_o (trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] opc);
    return {opc, 26'h2a5a5a5};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Field order: rdy ir_wrt reg_dst alu_src mem_to_reg alu_op reg_wrt mem_rd mem_wrt
  // pc_src retire trap trap_cause
  task automatic ea(input string tag, input logic rdy, input logic irw, input logic rd,
                    input logic as, input logic mtr, input logic [2:0] op, input logic rw,
                    input logic mr, input logic mw, input logic [1:0] pcs, input logic ret,
                    input logic trp, input logic [1:0] cause);
    logic [16:0] obs, exp;
    obs = {instr_rdy, ir_wrt, reg_dst, alu_src, mem_to_reg, alu_op, reg_wrt, mem_rd, mem_wrt,
           pc_src, retire, trap, trap_cause};
    exp = {rdy, irw, rd, as, mtr, op, rw, mr, mw, pcs, ret, trp, cause};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic rst_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1 ea(tag, 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0, 2'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b1;
    instr_vld = 1'b0;
    instr     = '0;
    zero      = 1'b0;
    mem_ack   = 1'b0;
    #1 rst_n = 1'b0;
    #1 ea("reset_async", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0, 2'd0);
    tick();
    ea("reset_held", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0, 2'd0);
    rst_n = 1'b1;
    tick();
    ea("idle", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0, 2'd0);

    // addi: ALU path, retire four cycles after accept
    instr = mk(6'b010000); instr_vld = 1'b1; tick();
    ea("addi_c1", 0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0, 2'd0);
    instr_vld = 1'b0; tick();
    ea("addi_c2", 0, 0, 0, 1, 0, 3'd3, 0, 0, 0, 2'd0, 0, 0, 2'd0); tick();
    ea("addi_c3", 0, 0, 0, 1, 0, 3'd3, 0, 0, 0, 2'd0, 0, 0, 2'd0); tick();
    ea("addi_c4", 1, 0, 0, 1, 0, 3'd3, 1, 0, 0, 2'd0, 1, 0, 2'd0); tick();
    ea("addi_c5", 1, 0, 0, 1, 0, 3'd3, 0, 0, 0, 2'd0, 0, 0, 2'd0);

    // beq with zero=1: taken
    instr = mk(6'b010011); instr_vld = 1'b1; tick();
    ea("beq_c1", 0, 1, 0, 1, 0, 3'd3, 0, 0, 0, 2'd0, 0, 0, 2'd0);
    instr_vld = 1'b0; zero = 1'b1; tick();
    ea("beq_c2", 0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 2'd0, 0, 0, 2'd0); tick();
    ea("beq_c3", 1, 0, 0, 0, 0, 3'd1, 0, 0, 0, 2'd1, 1, 0, 2'd0); tick();
    ea("beq_c4", 1, 0, 0, 0, 0, 3'd1, 0, 0, 0, 2'd0, 0, 0, 2'd0);

    // bne with zero=1: not taken
    instr = mk(6'b010100); instr_vld = 1'b1; tick();
    ea("bne1_c1", 0, 1, 0, 0, 0, 3'd1, 0, 0, 0, 2'd0, 0, 0, 2'd0);
    instr_vld = 1'b0; tick();
    ea("bne1_c2", 0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 2'd0, 0, 0, 2'd0); tick();
    ea("bne1_c3", 1, 0, 0, 0, 0, 3'd1, 0, 0, 0, 2'd0, 1, 0, 2'd0);

    // bne with zero=0: taken
    zero = 1'b0; instr_vld = 1'b1; tick();
    instr_vld = 1'b0; tick(); tick();
    ea("bne0_c3", 1, 0, 0, 0, 0, 3'd1, 0, 0, 0, 2'd1, 1, 0, 2'd0);

    // j, j, rtype with instr_vld held high
    instr = mk(6'b110000); instr_vld = 1'b1; tick();
    ea("b2b_c1", 0, 1, 0, 0, 0, 3'd1, 0, 0, 0, 2'd0, 0, 0, 2'd0); tick();
    ea("b2b_c2", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd2, 1, 0, 2'd0); tick();
    ea("b2b_c3", 0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0, 2'd0);
    instr = mk(6'b000000); tick();
    ea("b2b_c4", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd2, 1, 0, 2'd0); tick();
    ea("b2b_c5", 0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0, 2'd0); tick();
    ea("b2b_c6", 0, 0, 1, 0, 0, 3'd2, 0, 0, 0, 2'd0, 0, 0, 2'd0); tick();
    ea("b2b_c7", 0, 0, 1, 0, 0, 3'd2, 0, 0, 0, 2'd0, 0, 0, 2'd0); tick();
    ea("b2b_c8", 1, 0, 1, 0, 0, 3'd2, 1, 0, 0, 2'd0, 1, 0, 2'd0);
    instr_vld = 1'b0; tick();
    ea("b2b_c9", 1, 0, 1, 0, 0, 3'd2, 0, 0, 0, 2'd0, 0, 0, 2'd0);

    // lw with ack after three wait cycles
    instr = mk(6'b010101); instr_vld = 1'b1; tick();
    ea("lw_c1", 0, 1, 1, 0, 0, 3'd2, 0, 0, 0, 2'd0, 0, 0, 2'd0);
    instr_vld = 1'b0; tick();
    ea("lw_c2", 0, 0, 0, 1, 1, 3'd0, 0, 0, 0, 2'd0, 0, 0, 2'd0); tick();
    for (int i = 0; i < 4; i++) begin
      ea("lw_mem", 0, 0, 0, 1, 1, 3'd0, 0, 1, 0, 2'd0, 0, 0, 2'd0);
      if (i == 3) mem_ack = 1'b1;
      tick();
    end
    ea("lw_c7", 0, 0, 0, 1, 1, 3'd0, 0, 0, 0, 2'd0, 0, 0, 2'd0);
    mem_ack = 1'b0; tick();
    ea("lw_wb", 1, 0, 0, 1, 1, 3'd0, 1, 0, 0, 2'd0, 1, 0, 2'd0);

    // reset asserted while lw waits in MEM
    instr_vld = 1'b1; tick();
    instr_vld = 1'b0; tick(); tick();
    ea("lwr_mem", 0, 0, 0, 1, 1, 3'd0, 0, 1, 0, 2'd0, 0, 0, 2'd0);
    rst_pulse("lwr_rst");
    tick();
    ea("lwr_idle", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0, 2'd0);

    // sw with no ack: timeout after 15 MEM cycles
    instr = mk(6'b010110); instr_vld = 1'b1; tick();
    ea("sw_c1", 0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0, 2'd0);
    instr_vld = 1'b0; tick();
    ea("sw_c2", 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0, 2'd0); tick();
    for (int i = 0; i < 15; i++) begin
      ea("sw_mem", 0, 0, 0, 1, 0, 3'd0, 0, 0, 1, 2'd0, 0, 0, 2'd0);
      tick();
    end
    ea("sw_timeout", 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 2'd0, 0, 1, 2'd2);
    instr_vld = 1'b1; mem_ack = 1'b1; tick(); tick();
    ea("sw_sticky", 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 2'd0, 0, 1, 2'd2);
    instr_vld = 1'b0; mem_ack = 1'b0;
    rst_pulse("sw_rst");
    tick();
    ea("sw_idle", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0, 2'd0);

    // illegal opcode traps from DECODE
    instr = mk(6'b111111); instr_vld = 1'b1; tick();
    ea("ill_c1", 0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0, 2'd0);
    instr_vld = 1'b0; tick();
    ea("ill_c2", 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 1, 2'd1); tick();
    ea("ill_hold", 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 1, 2'd1);
    rst_pulse("ill_rst");
    tick();
    ea("ill_idle", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
